// File: rtl/axil_client_bridge.sv
// AXI4-Lite slave that serialises one read or write at a time into a single-beat
// valid/ready downstream request and returns the buffered downstream response.
module axil_client_bridge #(
    parameter int axil_data_width_p = 32,
    parameter int axil_addr_width_p = 32,
    parameter int rsp_els_p         = 2
) (
    input  logic                           clk_i,
    input  logic                           rst_ni,
    input  logic [axil_addr_width_p-1:0]   s_axil_awaddr_i,
    input  logic [2:0]                     s_axil_awprot_i,
    input  logic                           s_axil_awvalid_i,
    output logic                           s_axil_awready_o,
    input  logic [axil_data_width_p-1:0]   s_axil_wdata_i,
    input  logic [axil_data_width_p/8-1:0] s_axil_wstrb_i,
    input  logic                           s_axil_wvalid_i,
    output logic                           s_axil_wready_o,
    output logic [1:0]                     s_axil_bresp_o,
    output logic                           s_axil_bvalid_o,
    input  logic                           s_axil_bready_i,
    input  logic [axil_addr_width_p-1:0]   s_axil_araddr_i,
    input  logic [2:0]                     s_axil_arprot_i,
    input  logic                           s_axil_arvalid_i,
    output logic                           s_axil_arready_o,
    output logic [axil_data_width_p-1:0]   s_axil_rdata_o,
    output logic [1:0]                     s_axil_rresp_o,
    output logic                           s_axil_rvalid_o,
    input  logic                           s_axil_rready_i,
    output logic                           v_o,
    input  logic                           ready_and_i,
    output logic [axil_addr_width_p-1:0]   addr_o,
    output logic                           wr_en_o,
    output logic [1:0]                     data_size_o,
    output logic [axil_data_width_p-1:0]   wdata_o,
    input  logic                           v_i,
    input  logic [axil_data_width_p-1:0]   rdata_i
);
    localparam int strb_w_lp = axil_data_width_p / 8;
    localparam int ptr_w_lp  = (rsp_els_p > 1) ? $clog2(rsp_els_p) : 1;
    localparam int cnt_w_lp  = $clog2(rsp_els_p + 1);
    localparam logic [1:0]             full_size_lp = 2'($clog2(strb_w_lp));
    localparam logic [strb_w_lp-1:0]   strb_one_lp  = strb_w_lp'(1);
    localparam logic [ptr_w_lp-1:0]    ptr_last_lp  = ptr_w_lp'(rsp_els_p - 1);
    localparam logic [cnt_w_lp-1:0]    cnt_full_lp  = cnt_w_lp'(rsp_els_p);
    localparam logic [cnt_w_lp-1:0]    cnt_one_lp   = cnt_w_lp'(1);

    typedef enum logic [1:0] {IDLE, REQ, WAIT, RESP} state_e;

    state_e                         state_q, state_d;
    logic [axil_addr_width_p-1:0]   addr_q, addr_d;
    logic                           wr_en_q, wr_en_d;
    logic [1:0]                     size_q, size_d;
    logic [axil_data_width_p-1:0]   wdata_q, wdata_d;
    logic                           outst_q, outst_d;
    logic [axil_data_width_p-1:0]   mem_q [rsp_els_p];
    logic [axil_data_width_p-1:0]   mem_d [rsp_els_p];
    logic [ptr_w_lp-1:0]            wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [cnt_w_lp-1:0]            cnt_q, cnt_d;

    logic wr_acc, rd_acc, push, pop, rsp_hs;
    logic unused_prot;

    // Non-contiguous strobes are not a legal narrow access, so they issue full width.
    function automatic logic [1:0] strb_to_size(input logic [strb_w_lp-1:0] strb);
        logic [strb_w_lp-1:0] fill;
        int unsigned ones;
        ones = 0;
        for (int i = 0; i < strb_w_lp; i++) begin
            if (strb[i]) ones++;
        end
        fill = (strb | (strb - strb_one_lp)) + strb_one_lp;
        if ((fill & strb) != '0) return full_size_lp;
        case (ones)
            1:       return 2'd0;
            2:       return 2'd1;
            4:       return 2'd2;
            8:       return 2'd3;
            default: return full_size_lp;
        endcase
    endfunction

    function automatic logic [ptr_w_lp-1:0] ptr_inc(input logic [ptr_w_lp-1:0] p);
        return (p == ptr_last_lp) ? '0 : p + ptr_w_lp'(1);
    endfunction

    assign unused_prot = ^{s_axil_awprot_i, s_axil_arprot_i};

    assign wr_acc = rst_ni && (state_q == IDLE) && s_axil_awvalid_i && s_axil_wvalid_i;
    assign rd_acc = rst_ni && (state_q == IDLE) && s_axil_arvalid_i
                    && !(s_axil_awvalid_i && s_axil_wvalid_i);

    assign s_axil_awready_o = wr_acc;
    assign s_axil_wready_o  = wr_acc;
    assign s_axil_arready_o = rd_acc;

    assign v_o         = (state_q == REQ);
    assign addr_o      = addr_q;
    assign wr_en_o     = wr_en_q;
    assign data_size_o = size_q;
    assign wdata_o     = wdata_q;

    assign s_axil_bvalid_o = (state_q == RESP) && wr_en_q;
    assign s_axil_rvalid_o = (state_q == RESP) && !wr_en_q;
    assign s_axil_bresp_o  = 2'b00;
    assign s_axil_rresp_o  = 2'b00;
    assign s_axil_rdata_o  = (cnt_q != '0) ? mem_q[rd_ptr_q] : '0;

    assign rsp_hs = (s_axil_bvalid_o && s_axil_bready_i) || (s_axil_rvalid_o && s_axil_rready_i);
    assign push   = v_i && (cnt_q != cnt_full_lp);
    assign pop    = rsp_hs;

    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        cnt_d    = cnt_q;
        if (push) begin
            mem_d[wr_ptr_q] = rdata_i;
            wr_ptr_d        = ptr_inc(wr_ptr_q);
        end
        if (pop) rd_ptr_d = ptr_inc(rd_ptr_q);
        case ({push, pop})
            2'b10:   cnt_d = cnt_q + cnt_one_lp;
            2'b01:   cnt_d = cnt_q - cnt_one_lp;
            default: cnt_d = cnt_q;
        endcase
    end

    // Set on the request handshake, cleared on the response handshake; set dominates.
    always_comb begin
        outst_d = outst_q;
        if (pop) outst_d = 1'b0;
        if ((state_q == REQ) && ready_and_i) outst_d = 1'b1;
    end

    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        wr_en_d = wr_en_q;
        size_d  = size_q;
        wdata_d = wdata_q;
        case (state_q)
            IDLE: begin
                if (wr_acc || rd_acc) begin
                    state_d = REQ;
                    addr_d  = wr_acc ? s_axil_awaddr_i : s_axil_araddr_i;
                    wr_en_d = wr_acc;
                    size_d  = wr_acc ? strb_to_size(s_axil_wstrb_i) : full_size_lp;
                    wdata_d = wr_acc ? s_axil_wdata_i : '0;
                end
            end
            // A response pushed in the grant cycle lets us skip WAIT entirely.
            REQ:     if (ready_and_i) state_d = (cnt_d != '0) ? RESP : WAIT;
            WAIT:    if (outst_q && (cnt_d != '0)) state_d = RESP;
            RESP:    if (rsp_hs) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q  <= IDLE;
            addr_q   <= '0;
            wr_en_q  <= 1'b0;
            size_q   <= '0;
            wdata_q  <= '0;
            outst_q  <= 1'b0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
        end else begin
            state_q  <= state_d;
            addr_q   <= addr_d;
            wr_en_q  <= wr_en_d;
            size_q   <= size_d;
            wdata_q  <= wdata_d;
            outst_q  <= outst_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            cnt_q    <= cnt_d;
        end
    end

    always_ff @(posedge clk_i) begin
        mem_q <= mem_d;
    end

endmodule

// File: tb/tb_axil_client_bridge.sv
// Directed and randomized transactions against axil_client_bridge, checked against
// expectations derived from transaction-level rules.
module tb_axil_client_bridge;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [31:0] awaddr = '0;
    logic [2:0]  awprot = '0;
    logic        awvalid = 1'b0;
    logic        awready;
    logic [31:0] wdata = '0;
    logic [3:0]  wstrb = '0;
    logic        wvalid = 1'b0;
    logic        wready;
    logic [1:0]  bresp;
    logic        bvalid;
    logic        bready = 1'b0;
    logic [31:0] araddr = '0;
    logic [2:0]  arprot = '0;
    logic        arvalid = 1'b0;
    logic        arready;
    logic [31:0] rdata;
    logic [1:0]  rresp;
    logic        rvalid;
    logic        rready = 1'b0;
    logic        v_o;
    logic        ready_and = 1'b0;
    logic [31:0] addr_o;
    logic        wr_en_o;
    logic [1:0]  size_o;
    logic [31:0] wdata_o;
    logic        v_i = 1'b0;
    logic [31:0] rdata_i = '0;

    int total = 0;
    int bad = 0;

    always #5 clk = ~clk;

    axil_client_bridge dut (
        .clk_i(clk), .rst_ni(rst_n),
        .s_axil_awaddr_i(awaddr), .s_axil_awprot_i(awprot), .s_axil_awvalid_i(awvalid),
        .s_axil_awready_o(awready),
        .s_axil_wdata_i(wdata), .s_axil_wstrb_i(wstrb), .s_axil_wvalid_i(wvalid),
        .s_axil_wready_o(wready),
        .s_axil_bresp_o(bresp), .s_axil_bvalid_o(bvalid), .s_axil_bready_i(bready),
        .s_axil_araddr_i(araddr), .s_axil_arprot_i(arprot), .s_axil_arvalid_i(arvalid),
        .s_axil_arready_o(arready),
        .s_axil_rdata_o(rdata), .s_axil_rresp_o(rresp), .s_axil_rvalid_o(rvalid),
        .s_axil_rready_i(rready),
        .v_o(v_o), .ready_and_i(ready_and), .addr_o(addr_o), .wr_en_o(wr_en_o),
        .data_size_o(size_o), .wdata_o(wdata_o), .v_i(v_i), .rdata_i(rdata_i)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #2;
    endtask

    // Size expected from the strobe: contiguous 1/2/4 bytes are narrow, anything else is full word.
    function automatic logic [1:0] model_size(input bit wr, input logic [3:0] strb);
        int ones, first, last;
        ones = 0; first = -1; last = -1;
        if (!wr) return 2'd2;
        for (int i = 0; i < 4; i++) begin
            if (strb[i]) begin
                ones++;
                if (first < 0) first = i;
                last = i;
            end
        end
        if (ones == 0 || (last - first + 1) != ones) return 2'd2;
        case (ones)
            1:       return 2'd0;
            2:       return 2'd1;
            default: return 2'd2;
        endcase
    endfunction

    task automatic check_all_zero(input string tag);
        check({tag, "_ctl"}, {v_o, awready, wready, arready, bvalid, rvalid}, 6'd0);
        check({tag, "_addr"}, addr_o, 32'd0);
        check({tag, "_wdata"}, wdata_o, 32'd0);
        check({tag, "_size"}, size_o, 2'd0);
        check({tag, "_wr_en"}, wr_en_o, 1'b0);
        check({tag, "_rdata"}, rdata, 32'd0);
    endtask

    task automatic txn(input bit wr, input logic [31:0] addr, input logic [31:0] data,
                       input logic [3:0] strb, input logic [31:0] rsp,
                       input int req_stall, input int rsp_dly, input int rdy_stall);
        logic [1:0]  esize;
        logic [31:0] ewdata;
        esize  = model_size(wr, strb);
        ewdata = wr ? data : 32'd0;
        if (wr) begin
            awaddr = addr; wdata = data; wstrb = strb; awvalid = 1'b1; wvalid = 1'b1;
        end else begin
            araddr = addr; arvalid = 1'b1;
        end
        #1;
        check("accept_ready", {awready, wready, arready}, wr ? 3'b110 : 3'b001);
        cyc();
        awvalid = 1'b0; wvalid = 1'b0; arvalid = 1'b0;
        for (int i = 0; i <= req_stall; i++) begin
            check("req_v", v_o, 1'b1);
            check("req_addr", addr_o, addr);
            check("req_wr_en", wr_en_o, wr);
            check("req_size", size_o, esize);
            check("req_wdata", wdata_o, ewdata);
            if (i < req_stall) cyc();
        end
        ready_and = 1'b1;
        if (rsp_dly == 0) begin
            v_i = 1'b1; rdata_i = rsp;
        end
        cyc();
        ready_and = 1'b0; v_i = 1'b0; rdata_i = ~rsp;
        check("req_v_drop", v_o, 1'b0);
        if (rsp_dly > 0) begin
            for (int i = 1; i < rsp_dly; i++) begin
                check("no_early_rsp", {bvalid, rvalid}, 2'b00);
                cyc();
            end
            check("no_early_rsp", {bvalid, rvalid}, 2'b00);
            v_i = 1'b1; rdata_i = rsp;
            cyc();
            v_i = 1'b0; rdata_i = ~rsp;
        end
        awaddr = $urandom; araddr = $urandom;
        awvalid = 1'b1; wvalid = 1'b1; arvalid = 1'b1;
        for (int i = 0; i <= rdy_stall; i++) begin
            #1;
            check("rsp_valid", {bvalid, rvalid}, wr ? 2'b10 : 2'b01);
            check("rsp_code", wr ? bresp : rresp, 2'b00);
            if (!wr) check("rsp_rdata", rdata, rsp);
            check("no_accept_busy", {awready, wready, arready}, 3'b000);
            if (i < rdy_stall) cyc();
        end
        awvalid = 1'b0; wvalid = 1'b0; arvalid = 1'b0;
        if (wr) bready = 1'b1; else rready = 1'b1;
        cyc();
        bready = 1'b0; rready = 1'b0;
        check("rsp_done", {bvalid, rvalid}, 2'b00);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] d0, d1;
        bit          wr;

        cyc();
        check_all_zero("reset");
        rst_n = 1'b1;
        cyc();

        txn(1'b1, 32'h10, 32'hDEADBEEF, 4'hF, $urandom, 0, 0, 0);
        txn(1'b0, 32'h2000, 32'd0, 4'h0, 32'h12345678, 0, 0, 0);

        txn(1'b1, 32'h100, $urandom, 4'h1, $urandom, 0, 0, 0);
        txn(1'b1, 32'h104, $urandom, 4'h3, $urandom, 0, 1, 0);
        txn(1'b1, 32'h108, $urandom, 4'hF, $urandom, 1, 0, 1);
        txn(1'b1, 32'h10C, $urandom, 4'h5, $urandom, 0, 0, 0);
        txn(1'b1, 32'h110, $urandom, 4'h6, $urandom, 0, 2, 0);
        txn(1'b1, 32'h114, $urandom, 4'h0, $urandom, 0, 0, 0);
        txn(1'b1, 32'h118, $urandom, 4'hC, $urandom, 0, 0, 0);

        txn(1'b0, 32'h40, 32'd0, 4'h0, $urandom, 5, 3, 4);

        for (int n = 0; n < 10; n++) begin
            wr = 1'($urandom_range(0, 1));
            txn(wr, $urandom, $urandom, 4'($urandom_range(0, 15)), $urandom,
                $urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 3));
        end

        // Write and read offered together: write first, read right after B handshake.
        d0 = $urandom;
        awaddr = 32'h80; wdata = d0; wstrb = 4'hF; awvalid = 1'b1; wvalid = 1'b1;
        araddr = 32'h3000; arvalid = 1'b1;
        #1;
        check("both_ready", {awready, wready, arready}, 3'b110);
        cyc();
        awvalid = 1'b0; wvalid = 1'b0;
        #1;
        check("both_req_wr", {v_o, wr_en_o, arready}, 3'b110);
        check("both_req_wdata", wdata_o, d0);
        ready_and = 1'b1; v_i = 1'b1; rdata_i = $urandom;
        cyc();
        ready_and = 1'b0; v_i = 1'b0;
        #1;
        check("both_bvalid", {bvalid, arready}, 2'b10);
        bready = 1'b1;
        cyc();
        bready = 1'b0;
        #1;
        check("both_ar_next", arready, 1'b1);
        cyc();
        arvalid = 1'b0;
        check("both_rd_req", {v_o, wr_en_o}, 2'b10);
        check("both_rd_addr", addr_o, 32'h3000);
        d1 = $urandom;
        ready_and = 1'b1; v_i = 1'b1; rdata_i = d1;
        cyc();
        ready_and = 1'b0; v_i = 1'b0;
        check("both_rvalid", rvalid, 1'b1);
        check("both_rdata", rdata, d1);
        rready = 1'b1;
        cyc();
        rready = 1'b0;

        // Reset while waiting for a write response.
        awaddr = 32'h55AA; wdata = 32'hCAFEF00D; wstrb = 4'h3; awvalid = 1'b1; wvalid = 1'b1;
        cyc();
        awvalid = 1'b0; wvalid = 1'b0;
        ready_and = 1'b1;
        cyc();
        ready_and = 1'b0;
        check("wait_state", {v_o, bvalid, rvalid}, 3'b000);
        #1;
        rst_n = 1'b0; awvalid = 1'b1; wvalid = 1'b1; v_i = 1'b1; rdata_i = 32'hBAD0BAD0;
        #1;
        check_all_zero("rst_wait");
        cyc();
        cyc();
        awvalid = 1'b0; wvalid = 1'b0; v_i = 1'b0;
        rst_n = 1'b1;
        cyc();
        txn(1'b0, 32'h700, 32'd0, 4'h0, 32'h0BADF00D ^ 32'hFFFF0000, 0, 1, 0);

        // Reset while a read response sits in the FIFO.
        d0 = $urandom;
        araddr = 32'h900; arvalid = 1'b1;
        cyc();
        arvalid = 1'b0;
        ready_and = 1'b1; v_i = 1'b1; rdata_i = d0;
        cyc();
        ready_and = 1'b0; v_i = 1'b0;
        check("resp_pending", {rvalid, rdata}, {1'b1, d0});
        #1;
        rst_n = 1'b0;
        #1;
        check_all_zero("rst_resp");
        cyc();
        rst_n = 1'b1;
        cyc();
        d1 = ~d0;
        txn(1'b0, 32'hA00, 32'd0, 4'h0, d1, 0, 0, 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
